// File: rtl/bidir_fifo_port_ctrl_if.sv
// bidir_fifo_port_ctrl_if: local TX/RX streams plus the raw FIFO side port of one FIFO side
interface bidir_fifo_port_ctrl_if #(parameter int DSIZE = 8);
  logic dir_req, dir, busy;
  logic tx_valid, tx_ready;
  logic [DSIZE-1:0] tx_data;
  logic rx_valid, rx_ready;
  logic [DSIZE-1:0] rx_data;
  logic fifo_winc, fifo_full;
  logic [DSIZE-1:0] fifo_wdata;
  logic fifo_rinc, fifo_empty;
  logic [DSIZE-1:0] fifo_rdata;
  logic [15:0] turn_count;
  modport master(
    input dir_req, tx_valid, tx_data, rx_ready, fifo_full, fifo_rdata, fifo_empty,
    output dir, busy, tx_ready, rx_valid, rx_data, fifo_winc, fifo_wdata, fifo_rinc, turn_count
  );
  modport slave(
    output dir_req, tx_valid, tx_data, rx_ready, fifo_full, fifo_rdata, fifo_empty,
    input dir, busy, tx_ready, rx_valid, rx_data, fifo_winc, fifo_wdata, fifo_rinc, turn_count
  );
endinterface

// File: rtl/bidir_fifo_port_ctrl.sv
// bidir_fifo_port_ctrl: direction owner for one side of the bidirectional FIFO; BIDIR_PORT_CTRL_STATS_EN adds a turnaround counter
module bidir_fifo_port_ctrl #(
  parameter int DSIZE     = 8,
  parameter int TURN_WAIT = 4
) (
  input logic clk,
  input logic rst_n,
  bidir_fifo_port_ctrl_if.master bus
);
  typedef enum logic [1:0] {READ, WRITE, TURN} state_t;
  state_t state, state_next;
  logic dir_q, rx_valid_q, turn_done, tx_ready_c, rinc_c;
  logic [7:0] turn_cnt;
  logic [DSIZE-1:0] rx_data_q;
  assign turn_done = state == TURN && turn_cnt == 8'd0;
  // state, direction and guard counter; the counter is loaded on every TURN entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= READ;
      dir_q    <= 1'b0;
      turn_cnt <= '0;
    end else begin
      state    <= state_next;
      dir_q    <= turn_done ? !dir_q : dir_q;
      turn_cnt <= (state != TURN && state_next == TURN) ? 8'(TURN_WAIT - 1) :
                  (state == TURN && turn_cnt != 8'd0) ? turn_cnt - 8'd1 : turn_cnt;
    end
  // next state; READ only leaves once the FIFO and the local holding register are both empty
  always_comb begin
    state_next = state;
    case (state)
      READ:    if (bus.dir_req && bus.fifo_empty && !rx_valid_q) state_next = TURN;
      WRITE:   if (!bus.dir_req) state_next = TURN;
      default: if (turn_cnt == 8'd0) state_next = dir_q ? READ : WRITE;
    endcase
  end
  assign tx_ready_c     = state == WRITE && !bus.fifo_full;
  assign rinc_c         = state == READ && !bus.fifo_empty && (!rx_valid_q || bus.rx_ready);
  assign bus.tx_ready   = tx_ready_c;
  assign bus.fifo_winc  = bus.tx_valid && tx_ready_c;
  assign bus.fifo_wdata = state == WRITE ? bus.tx_data : '0;
  assign bus.fifo_rinc  = rinc_c;
  assign bus.dir        = dir_q;
  assign bus.busy       = state == TURN;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_data    = rx_data_q;
  // RX output register: load on FIFO read, clear when consumed without a refill
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else if (rinc_c) begin
      rx_valid_q <= 1'b1;
      rx_data_q  <= bus.fifo_rdata;
    end else if (bus.rx_ready) begin
      rx_valid_q <= 1'b0;
    end
`ifdef BIDIR_PORT_CTRL_STATS_EN
  logic [15:0] turn_count_q;
  // completed turnarounds, saturating
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) turn_count_q <= '0;
    else if (turn_done && turn_count_q != 16'hFFFF) turn_count_q <= turn_count_q + 16'd1;
  assign bus.turn_count = turn_count_q;
`else
  assign bus.turn_count = '0;
`endif
endmodule

// File: tb/tb_bidir_fifo_port_ctrl.sv
// tb_bidir_fifo_port_ctrl: scoreboard bench for the port controller against a FIFO-side model
module tb_bidir_fifo_port_ctrl;
  localparam int DSIZE = 8;
`ifdef BIDIR_PORT_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nvec = 0;
  int nerr = 0;
  logic [7:0] rdq[$];
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] mon_e;

  bidir_fifo_port_ctrl_if #(.DSIZE(DSIZE)) bus();
  bidir_fifo_port_ctrl #(.DSIZE(DSIZE), .TURN_WAIT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // first-word fall-through FIFO read side
  always @(posedge clk) begin
    if (bus.fifo_rinc && rdq.size() > 0) void'(rdq.pop_front());
    bus.fifo_empty <= rdq.size() == 0;
    bus.fifo_rdata <= rdq.size() > 0 ? rdq[0] : 8'h00;
  end

  // scoreboard and protocol monitor
  always @(negedge clk) if (rst_n) begin
    if (bus.rx_valid && !bus.rx_ready) begin
      nvec++;
      if (bus.fifo_rinc !== 1'b0) begin nerr++; $display("FAIL rx_stall_rinc: got %b expected 0", bus.fifo_rinc); end
    end
    if (bus.rx_valid && bus.rx_ready) begin
      nvec++;
      if (exp_rx.size() == 0) begin nerr++; $display("FAIL rx_extra: got %h expected none", bus.rx_data); end
      else begin
        mon_e = exp_rx.pop_front();
        if (bus.rx_data !== mon_e) begin nerr++; $display("FAIL rx_data: got %h expected %h", bus.rx_data, mon_e); end
      end
    end
    if (bus.fifo_winc) begin
      nvec++;
      if (exp_tx.size() == 0) begin nerr++; $display("FAIL tx_extra: got %h expected none", bus.fifo_wdata); end
      else begin
        mon_e = exp_tx.pop_front();
        if (bus.fifo_wdata !== mon_e) begin nerr++; $display("FAIL tx_wdata: got %h expected %h", bus.fifo_wdata, mon_e); end
      end
    end
    if (bus.fifo_full && bus.dir && !bus.busy) begin
      nvec++;
      if ({bus.tx_ready, bus.fifo_winc} !== 2'b00) begin nerr++; $display("FAIL full_stall: got %b expected 00", {bus.tx_ready, bus.fifo_winc}); end
    end
    if (bus.busy) begin
      nvec++;
      if ({bus.fifo_winc, bus.fifo_rinc, bus.tx_ready} !== 3'b000) begin nerr++; $display("FAIL turn_quiet: got %b expected 000", {bus.fifo_winc, bus.fifo_rinc, bus.tx_ready}); end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.dir_req = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0; bus.rx_ready = 1'b0; bus.fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nvec += 4;
    if (bus.dir !== 1'b0) begin nerr++; $display("FAIL rst_dir: got %b expected 0", bus.dir); end
    if ({bus.busy, bus.rx_valid, bus.tx_ready, bus.fifo_rinc, bus.fifo_winc} !== 5'b0) begin nerr++; $display("FAIL rst_flags: got %b expected 00000", {bus.busy, bus.rx_valid, bus.tx_ready, bus.fifo_rinc, bus.fifo_winc}); end
    if (bus.turn_count !== 16'd0) begin nerr++; $display("FAIL rst_turn_count: got %0d expected 0", bus.turn_count); end
    if ({bus.rx_data, bus.fifo_wdata} !== 16'h0) begin nerr++; $display("FAIL rst_data: got %h expected 0000", {bus.rx_data, bus.fifo_wdata}); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_read();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin rdq.push_back(8'hA1 + 8'(i)); exp_rx.push_back(8'hA1 + 8'(i)); end
    for (int i = 0; i < 40 && exp_rx.size() > 0; i++) begin
      bus.rx_ready = i[0];
      @(posedge clk); #1;
    end
    @(negedge clk);
    nvec += 2;
    if (exp_rx.size() != 0) begin nerr++; $display("FAIL read_lost: got %0d left expected 0", exp_rx.size()); end
    if (bus.rx_valid !== 1'b0) begin nerr++; $display("FAIL read_dup: got rx_valid %b expected 0", bus.rx_valid); end
  endtask

  task automatic test_turn_to_write();
    int busy_n = 0;
    @(posedge clk); #1;
    rdq.push_back(8'hB1); rdq.push_back(8'hB2); exp_rx.push_back(8'hB1); exp_rx.push_back(8'hB2);
    bus.rx_ready = 1'b1;
    @(posedge clk); #1 bus.dir_req = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.dir) break;
    end
    nvec += 4;
    if (bus.dir !== 1'b1) begin nerr++; $display("FAIL r2w_timeout: got dir %b expected 1", bus.dir); end
    if (busy_n != 4) begin nerr++; $display("FAIL r2w_busy_len: got %0d expected 4", busy_n); end
    if (exp_rx.size() != 0) begin nerr++; $display("FAIL r2w_drain: got %0d left expected 0", exp_rx.size()); end
    if ({bus.tx_ready, bus.busy} !== 2'b10) begin nerr++; $display("FAIL r2w_ready: got %b expected 10", {bus.tx_ready, bus.busy}); end
  endtask

  task automatic test_write_full();
    int i = 0;
    int held = 0;
    for (int b = 0; b < 5; b++) exp_tx.push_back(8'h10 + 8'(b));
    @(posedge clk); #1;
    for (int c = 0; c < 40 && i < 5; c++) begin
      bus.tx_valid = 1'b1;
      bus.tx_data = 8'h10 + 8'(i);
      bus.fifo_full = i == 3 && held < 3;
      @(negedge clk);
      if (bus.fifo_winc) i++;
      if (bus.fifo_full) held++;
      @(posedge clk); #1;
    end
    bus.tx_valid = 1'b0; bus.fifo_full = 1'b0;
    nvec += 3;
    if (i != 5) begin nerr++; $display("FAIL write_count: got %0d expected 5", i); end
    if (held != 3) begin nerr++; $display("FAIL write_stall_cycles: got %0d expected 3", held); end
    if (exp_tx.size() != 0) begin nerr++; $display("FAIL write_lost: got %0d left expected 0", exp_tx.size()); end
  endtask

  task automatic test_turn_glitch();
    int busy_n = 0;
    int k;
    @(posedge clk); #1 bus.dir_req = 1'b0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.busy) begin busy_n++; bus.dir_req = busy_n != 2; end
      if (!bus.dir && !bus.busy) break;
    end
    nvec += 3;
    if (busy_n != 4) begin nerr++; $display("FAIL w2r_busy_len: got %0d expected 4", busy_n); end
    if (bus.dir !== 1'b0) begin nerr++; $display("FAIL w2r_dir: got %b expected 0", bus.dir); end
    if (bus.turn_count !== (STATS ? 16'd2 : 16'd0)) begin nerr++; $display("FAIL turn_count_2: got %0d expected %0d", bus.turn_count, STATS ? 2 : 0); end
    @(negedge clk);
    nvec++;
    if (bus.busy !== 1'b1) begin nerr++; $display("FAIL retrigger: got busy %b expected 1", bus.busy); end
    for (k = 0; k < 40 && !bus.dir; k++) @(negedge clk);
    nvec += 2;
    if (bus.dir !== 1'b1) begin nerr++; $display("FAIL retrigger_done: got dir %b expected 1", bus.dir); end
    if (bus.turn_count !== (STATS ? 16'd3 : 16'd0)) begin nerr++; $display("FAIL turn_count_3: got %0d expected %0d", bus.turn_count, STATS ? 3 : 0); end
  endtask

  task automatic test_reset_mid_turn();
    int busy_n = 0;
    @(posedge clk); #1 bus.dir_req = 1'b0;
    for (int k = 0; k < 20 && busy_n < 2; k++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
    end
    nvec++;
    if (busy_n != 2) begin nerr++; $display("FAIL mid_turn_timeout: got %0d expected 2", busy_n); end
    rst_n = 1'b0;
    #1;
    nvec += 2;
    if ({bus.dir, bus.busy, bus.rx_valid, bus.tx_ready} !== 4'b0) begin nerr++; $display("FAIL async_rst: got %b expected 0000", {bus.dir, bus.busy, bus.rx_valid, bus.tx_ready}); end
    if (bus.turn_count !== 16'd0) begin nerr++; $display("FAIL async_rst_count: got %0d expected 0", bus.turn_count); end
    @(posedge clk); #1 rst_n = 1'b1;
    rdq.push_back(8'hC1); rdq.push_back(8'hC2); exp_rx.push_back(8'hC1); exp_rx.push_back(8'hC2);
    bus.rx_ready = 1'b1;
    for (int k = 0; k < 40 && exp_rx.size() > 0; k++) begin @(posedge clk); #1; end
    nvec++;
    if (exp_rx.size() != 0) begin nerr++; $display("FAIL resume_read: got %0d left expected 0", exp_rx.size()); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_turn_to_write();
    test_write_full();
    test_turn_glitch();
    test_reset_mid_turn();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bidir_fifo_port_ctrl.md
# bidir_fifo_port_ctrl

Single-clock port controller that sits on one side of the dual-ported bidirectional async FIFO. It owns that side's direction bit. It turns the raw FIFO side port (`winc`/`wdata`/`full`, `rinc`/`rdata`/`empty`, `dir`) into two valid/ready streams for local logic: a TX stream into the FIFO and an RX stream out of it. It sequences every direction change through a drain-and-guard turnaround so no word is lost or read from a stale pointer. One instance per FIFO side, clocked by that side's clock.

## Interface
Parameters:
- `DSIZE`, 8, data width; must match the FIFO.
- `TURN_WAIT`, 4, guard cycles in TURN. Legal range 1..255. Must cover pointer-sync latency, 2 flops plus margin.

Ports:
- `clk` in 1: side clock.
- `rst_n` in 1: asynchronous active-low reset.
- `dir_req` in 1: requested direction; 1 = this side writes, 0 = this side reads.
- `dir` out 1: direction driven to the FIFO side port; 1 = write.
- `busy` out 1: high while in TURN.
- `tx_valid` in 1, `tx_ready` out 1, `tx_data` in DSIZE: write stream.
- `rx_valid` out 1, `rx_ready` in 1, `rx_data` out DSIZE: read stream, registered.
- `fifo_winc` out 1, `fifo_wdata` out DSIZE, `fifo_full` in 1: FIFO write side.
- `fifo_rinc` out 1, `fifo_rdata` in DSIZE, `fifo_empty` in 1: FIFO read side. The FIFO runs in first-word fall-through mode, so `fifo_rdata` is valid whenever `!fifo_empty`.
- `turn_count` out 16: completed turnarounds (see Configuration).

## Operation
- FSM states: READ (`dir`=0), WRITE (`dir`=1), TURN (`dir` holds its old value, no FIFO traffic). Reset state is READ.
- READ:
  - `fifo_rinc = !fifo_empty & (!rx_valid | rx_ready)`.
  - On `fifo_rinc`: `rx_data <= fifo_rdata`, `rx_valid <= 1`.
  - On `rx_valid & rx_ready` with no load: `rx_valid <= 0`.
  - `tx_ready` = 0.
- WRITE:
  - `tx_ready = !fifo_full`.
  - `fifo_winc = tx_valid & tx_ready`.
  - `fifo_wdata = tx_data`.
  - `fifo_rinc` = 0.
  - `rx_valid` stays 0.
- READ -> TURN requires all three: `dir_req`=1, `fifo_empty`=1 and `rx_valid`=0, i.e. local data fully drained. Reading continues while `dir_req`=1 until this holds.
- WRITE -> TURN when `dir_req`=0. It happens on the first such cycle; a beat accepted in that same cycle still completes.
- TURN:
  - 8-bit `turn_cnt` loads `TURN_WAIT-1` on entry and decrements each cycle.
  - On the cycle `turn_cnt`=0: `dir` toggles and the state goes to the target (WRITE if coming from READ, else READ).
  - TURN always completes. A `dir_req` change during TURN is ignored and is evaluated again from the new state.
  - `fifo_winc`, `fifo_rinc`, `tx_ready` are 0 throughout TURN.
- `fifo_winc`/`fifo_rinc` are never asserted together and never asserted against the current `dir`.

## Timing
- Reset values:
  - `dir`=0, `busy`=0, `rx_valid`=0, `rx_data`=0, `turn_count`=0, `turn_cnt`=0.
  - `tx_ready`=0, `fifo_winc`=0, `fifo_wdata`=0.
  - `fifo_rinc`=0 while `fifo_empty`=1.
- RX latency: 1 cycle from `fifo_rinc` to `rx_valid`/`rx_data`. Back-to-back reads sustain one word per cycle when `rx_ready`=1.
- TX is combinational pass-through with 0 latency. `tx_ready` drops in the same cycle `fifo_full` rises.
- Turnaround is exactly `TURN_WAIT` cycles in TURN. `busy` is high for exactly those cycles. `dir` changes on the clock edge that leaves TURN.
- Full/empty boundaries:
  - `fifo_full`=1 in WRITE: stall with no `winc`.
  - `fifo_empty`=1 in READ: hold `rx_valid` until consumed.
- Asynchronous reset mid-TURN or mid-transfer returns everything to the reset values immediately. A held `rx_data` word is discarded.

## Configuration
- `BIDIR_PORT_CTRL_STATS_EN` defined: `turn_count` increments by 1 on each TURN exit and saturates at 16'hFFFF.
- Not defined: `turn_count` is tied to 0 and no counter logic is built. The port exists in both builds.

## Test plan
- Reset with `fifo_empty`=1 -> `dir`=0, `rx_valid`=0, `tx_ready`=0, `fifo_rinc`=0; `turn_count`=0 in both builds.
- READ, FIFO presents 0xA1, 0xA2, 0xA3, `rx_ready` toggling 1/0 -> `rx_data` sequence is 0xA1, 0xA2, 0xA3 with no loss or duplicate; no `rinc` while `rx_valid` & !`rx_ready`.
- `dir_req`=1 with 2 words pending and `rx_ready`=1 -> both delivered, then `busy` high for exactly 4 cycles, then `dir`=1, `tx_ready`=1.
- WRITE, 5 `tx` beats 0x10..0x14 with `fifo_full` rising after beat 3 -> `tx_ready`=0 and no `winc` while full; beats 4 and 5 are written after full clears, in order.
- `dir_req` 1->0->1 inside TURN (WRITE->READ) -> TURN completes to READ after 4 cycles, then a new turnaround starts because `dir_req`=1 and the FIFO is drained; `turn_count`=2 with `BIDIR_PORT_CTRL_STATS_EN` defined.
- Assert `rst_n` low at TURN cycle 2 -> state READ, `dir`=0, `busy`=0 immediately; normal reads resume after release.
